// File: rtl/mul_div_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Multiply has a fixed configurable latency; divide is radix-2 restoring, one quotient bit per cycle.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;

  logic signed [WIDTH:0] mul_a;
  logic signed [WIDTH:0] mul_b;
  logic [WIDTH-1:0]      quo;
  logic [WIDTH-1:0]      rem;
  logic [WIDTH-1:0]      dvs;
  logic                  neg_q;
  logic                  neg_r;
  logic                  div_zero;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? -v : v;
  endfunction

  logic accept;
  logic signed_mul;
  logic signed_div;
  assign accept     = bus.start && (state == S_IDLE) && !bus.flush && (bus.op <= OP_MTLO);
  assign signed_mul = (bus.op == OP_MULT);
  assign signed_div = (bus.op == OP_DIV);

  // Multiplier: one extra sign/zero bit lets a single signed multiply serve MULT and MULTU.
  logic signed [WIDTH:0]  ext_a;
  logic signed [WIDTH:0]  ext_b;
  logic signed [WIDTH:0]  mop_a;
  logic signed [WIDTH:0]  mop_b;
  logic signed [PW-1:0]   prod_full;
  logic [2*WIDTH-1:0]     prod;
  logic [1:0]             unused_prod;
  assign ext_a       = {signed_mul & bus.a[WIDTH-1], bus.a};
  assign ext_b       = {signed_mul & bus.b[WIDTH-1], bus.b};
  assign mop_a       = (state == S_MUL) ? mul_a : ext_a;
  assign mop_b       = (state == S_MUL) ? mul_b : ext_b;
  assign prod_full   = PW'(mop_a) * PW'(mop_b);
  assign prod        = prod_full[2*WIDTH-1:0];
  assign unused_prod = prod_full[PW-1:2*WIDTH];

  // Restoring divide step: the remainder stays below the divisor, so bit WIDTH of diff is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

  // Operand stage: captured on accept, iterated while dividing
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_a    <= ext_a;
      mul_b    <= ext_b;
      quo      <= (signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      dvs      <= (signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      rem      <= '0;
      neg_q    <= signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r    <= signed_div & bus.a[WIDTH-1];
      div_zero <= (bus.b == '0);
    end else if (state == S_DIV) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

  // Control and architectural result stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (bus.op)
                OP_MTHI: hi_r <= bus.a;
                OP_MTLO: lo_r <= bus.a;
                OP_MULT, OP_MULTU: begin
                  if (MUL_CYCLES == 1) begin
                    {hi_r, lo_r} <= prod;
                    done_r       <= 1'b1;
                  end else begin
                    state <= S_MUL;
                    cnt   <= CW'(MUL_CYCLES - 1);
                  end
                end
                OP_DIV, OP_DIVU: begin
                  state <= S_DIV;
                  cnt   <= CW'(WIDTH);
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (cnt == CW'(1)) begin
              {hi_r, lo_r} <= prod;
              done_r       <= 1'b1;
              state        <= S_IDLE;
              cnt          <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_DIV: begin
            if (cnt == CW'(1)) begin
              hi_r   <= cond_neg(rem_next, neg_r);
              lo_r   <= div_zero ? '1 : cond_neg(quo_next, neg_q);
              done_r <= 1'b1;
              state  <= S_IDLE;
              cnt    <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized bench for mul_div_unit at WIDTH=32, MUL_CYCLES=2, checked against an arithmetic model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .MUL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0:    model = 64'(sa * sb);
      3'd1:    model = {32'd0, a} * {32'd0, b};
      3'd2:    model = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3:    model = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'd4:    model = {a, lo};
      3'd5:    model = {hi, a};
      default: model = {hi, lo};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1)      latency = 2;
    else if (op <= 3'd3) latency = 33;
    else                 latency = 1;
  endfunction

  // Issue in the current cycle (cycle 0); returns in the result cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int lat;
    lat = latency(op);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk({tag, "_busy"}, {62'd0, bus.busy, bus.done}, 64'b10);
      tick();
    end
    chk({tag, "_done"}, {62'd0, bus.busy, bus.done}, (op >= 3'd4) ? 64'b00 : 64'b01);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {ehi, elo});
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic run_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] e;
    e = model(op, a, b, m_hi, m_lo);
    run_op(op, a, b, e[63:32], e[31:0], tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       pick = 32'h0;
      1:       pick = 32'h1;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'h8000_0000;
      4:       pick = 32'h7FFF_FFFF;
      5:       pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int saw_done;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset_state", {bus.hi, bus.lo}, 64'd0);
    chk("reset_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;
    tick();

    // Multiply
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1x2");
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu_x2");

    // Signed divide, overflow, divide by zero
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");

    // Reset mid-divide at cycle 10
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_model(3'd0, 32'd3, 32'hFFFF_FFFC, "post_rst_mult");

    // MTHI, then DIV with an ignored start and a flush at cycle 10
    run_op(3'd4, 32'h1234, 32'd0, 32'h1234, m_lo, "mthi");
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("flush_prebusy", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    saw_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) saw_done++;
      tick();
    end
    chk("flush_nodone", 64'(saw_done), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, {32'h1234, m_lo});

    // MTLO with flush in the same cycle
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFE_F00D; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("mtlo_flush", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Reserved op is ignored
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hDEAD_BEEF; bus.b = 32'd1;
    tick();
    bus.start = 1'b0;
    chk("op6_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("op6_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Flush in the last divide cycle suppresses the write
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd50; bus.b = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (31) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("lateflush_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("lateflush_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Flush during multiply
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("mulflush_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("mulflush_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Back-to-back: MULTU issued in the DIVU done cycle
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_divu");
    run_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, "b2b_multu");

    // Randomized operations, issued back-to-back
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 5));
      a  = pick();
      b  = pick();
      run_model(op, a, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
